// File: rtl/imit_enc_array.sv
// Multi-channel quadrature encoder imitator: step/dir strobes are buffered in a
// signed pending counter and replayed as dwell-paced A/B/Z edges.
module imit_enc_array #(
  parameter int CH      = 2,
  parameter int PEND_W  = 8,
  parameter int DWELL_W = 16,
  parameter int CPR     = 1000
) (
  input  logic               clk,
  input  logic               aclr_n,
  input  logic [CH-1:0]      sclr,
  input  logic [CH-1:0]      step,
  input  logic [CH-1:0]      dir,
  input  logic [DWELL_W-1:0] dwell,
  output logic [CH-1:0]      A,
  output logic [CH-1:0]      B,
  output logic [CH-1:0]      Z,
  output logic [CH-1:0]      ovf,
  output logic [CH-1:0]      busy
);

  localparam int EW = (4 * CPR > 2) ? $clog2(4 * CPR) : 1;
  localparam logic [EW-1:0] E_LAST = EW'(4 * CPR - 1);
  localparam logic signed [PEND_W-1:0] P_MAX = {1'b0, {(PEND_W-1){1'b1}}};
  localparam logic signed [PEND_W-1:0] P_MIN = -P_MAX;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic signed [PEND_W-1:0] pend_q, pend_d;
      logic [DWELL_W-1:0]       dcnt_q, dcnt_d;
      logic [1:0]               p_q, p_d;
      logic [EW-1:0]            e_q, e_d;
      logic                     ovf_q, ovf_d;
      logic                     a_q, a_d, b_q, b_d, z_q, z_d;
      logic                     emit, fwd_em, s_up, s_dn, drop;

      always_comb begin
        emit   = (pend_q != '0) && (dcnt_q == '0);
        fwd_em = ~pend_q[PEND_W-1];
        s_up   = step[gi] & dir[gi];
        s_dn   = step[gi] & ~dir[gi];
        // A step at the limit survives only if a same-direction edge frees a slot
        drop   = (s_up && (pend_q == P_MAX) && !(emit && fwd_em)) ||
                 (s_dn && (pend_q == P_MIN) && !(emit && !fwd_em));

        pend_d = pend_q;
        if (s_up && !drop) pend_d = pend_d + PEND_W'(1);
        if (s_dn && !drop) pend_d = pend_d - PEND_W'(1);
        if (emit)          pend_d = fwd_em ? pend_d - PEND_W'(1) : pend_d + PEND_W'(1);

        ovf_d  = ovf_q | drop;
        dcnt_d = emit ? dwell : ((dcnt_q != '0) ? dcnt_q - DWELL_W'(1) : dcnt_q);

        p_d = p_q;
        e_d = e_q;
        if (emit) begin
          if (fwd_em) begin
            p_d = p_q + 2'd1;
            e_d = (e_q == E_LAST) ? '0 : e_q + EW'(1);
          end else begin
            p_d = p_q - 2'd1;
            e_d = (e_q == '0) ? E_LAST : e_q - EW'(1);
          end
        end

        if (sclr[gi]) begin
          pend_d = '0;
          dcnt_d = '0;
          p_d    = '0;
          e_d    = '0;
          ovf_d  = 1'b0;
        end

        // Outputs come straight from the next phase so they register glitch-free
        a_d = p_d[1] ^ p_d[0];
        b_d = p_d[1];
        z_d = (e_d == '0);
      end

      always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
          pend_q <= '0;
          dcnt_q <= '0;
          p_q    <= '0;
          e_q    <= '0;
          ovf_q  <= 1'b0;
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          z_q    <= 1'b1;
        end else begin
          pend_q <= pend_d;
          dcnt_q <= dcnt_d;
          p_q    <= p_d;
          e_q    <= e_d;
          ovf_q  <= ovf_d;
          a_q    <= a_d;
          b_q    <= b_d;
          z_q    <= z_d;
        end
      end

      assign A[gi]    = a_q;
      assign B[gi]    = b_q;
      assign Z[gi]    = z_q;
      assign ovf[gi]  = ovf_q;
      assign busy[gi] = (pend_q != '0);
    end
  endgenerate

endmodule

// File: tb/tb_imit_enc_array.sv
// Directed bench for imit_enc_array built with CPR=2 and PEND_W=4 so wrap and
// saturation are reachable in a few cycles.
module tb_imit_enc_array;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic [1:0]  sclr, step, dir;
  logic [15:0] dwell;
  logic [1:0]  A, B, Z, ovf, busy;
  logic [1:0]  ab0, ab1, prev;
  int          total = 0;
  int          bad = 0;
  int          edges;

  always #5 clk = ~clk;

  assign ab0 = {A[0], B[0]};
  assign ab1 = {A[1], B[1]};

  imit_enc_array #(.CH(2), .PEND_W(4), .DWELL_W(16), .CPR(2)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .step(step), .dir(dir),
    .dwell(dwell), .A(A), .B(B), .Z(Z), .ovf(ovf), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] e2;
    aclr_n = 1'b0; sclr = '0; step = '0; dir = '0; dwell = '0;
    repeat (2) tick;
    aclr_n = 1'b1;
    tick;
    check("rst_ab", {A, B}, 4'b0000);
    check("rst_z", Z, 2'b11);
    check("rst_ovf", ovf, 2'b00);
    check("rst_busy", busy, 2'b00);
    $display("reset checked");

    // single forward step, dwell 0
    step = 2'b01; dir = 2'b01;
    tick; step = '0;
    check("t1_busy", busy[0], 1'b1);
    check("t1_ab_early", ab0, 2'b00);
    tick;
    check("t1_ab", ab0, 2'b10);
    check("t1_z", Z[0], 1'b0);
    check("t1_busy_off", busy[0], 1'b0);
    tick;
    check("t1_hold", ab0, 2'b10);
    $display("single step checked");

    // five forward steps, dwell 3 -> edges 4 clocks apart
    sclr = 2'b01; tick; sclr = '0;
    check("t2_clr_ab", ab0, 2'b00);
    check("t2_clr_z", Z[0], 1'b1);
    dwell = 16'd3; step = 2'b01; dir = 2'b01;
    for (int i = 1; i <= 19; i++) begin
      tick;
      if (i == 5) step = '0;
      if (i < 2)       e2 = 2'b00;
      else if (i < 6)  e2 = 2'b10;
      else if (i < 10) e2 = 2'b11;
      else if (i < 14) e2 = 2'b01;
      else if (i < 18) e2 = 2'b00;
      else             e2 = 2'b10;
      check("t2_ab", ab0, e2);
      check("t2_busy", busy[0], (i < 18));
    end
    check("t2_ch1_idle", ab1, 2'b00);
    $display("dwell burst checked");

    // eight reverse steps with CPR=2: e walks 7..0
    sclr = 2'b01; tick; sclr = '0;
    dwell = '0; step = 2'b01; dir = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      tick;
      if (i == 8) step = '0;
      check("t3_z", Z[0], (i == 1 || i >= 9));
      if (i == 2) check("t3_ab_first", ab0, 2'b01);
      if (i == 5) check("t3_ab_mid", ab0, 2'b00);
    end
    check("t3_ab_end", ab0, 2'b00);
    check("t3_busy", busy[0], 1'b0);
    $display("reverse wrap checked");

    // saturation at +7 with dwell 100
    sclr = 2'b01; tick; sclr = '0;
    dwell = 16'd100; step = 2'b01; dir = 2'b01;
    for (int i = 1; i <= 9; i++) begin
      tick;
      if (i == 9) step = '0;
      if (i == 8) check("t4_ovf_pre", ovf[0], 1'b0);
    end
    check("t4_ovf", ovf[0], 1'b1);
    check("t4_ab", ab0, 2'b10);
    check("t4_busy", busy[0], 1'b1);
    step = 2'b01; dir = 2'b00;
    tick; step = '0;
    check("t4_ovf_sticky", ovf[0], 1'b1);
    dwell = '0;
    prev = ab0; edges = 0;
    for (int k = 0; k < 200 && busy[0]; k++) begin
      tick;
      if (ab0 != prev) edges++;
      prev = ab0;
    end
    check("t4_drain_edges", edges, 6);
    check("t4_ab_end", ab0, 2'b01);
    check("t4_drained", busy[0], 1'b0);
    check("t4_ovf_kept", ovf[0], 1'b1);
    sclr = 2'b01; tick; sclr = '0;
    check("t4_clr_ovf", ovf[0], 1'b0);
    check("t4_clr_busy", busy[0], 1'b0);
    check("t4_clr_ab", ab0, 2'b00);
    check("t4_clr_z", Z[0], 1'b1);
    $display("saturation checked");

    // alternating fwd/rev strobes, dwell 10
    dwell = 16'd10; step = 2'b01; dir = 2'b01;
    prev = ab0; edges = 0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (i <= 8) begin
        step = 2'b01;
        dir  = (i % 2 == 0) ? 2'b01 : 2'b00;
      end else begin
        step = '0;
      end
      check("t5_busy", busy[0], (i == 1) || ((i % 2 == 0) && (i <= 8)));
      if (ab0 != prev) edges++;
      prev = ab0;
    end
    check("t5_edges", edges, 1);
    check("t5_ab", ab0, 2'b10);
    $display("alternating strobes checked");

    // sclr[1] leaves ch0 alone; aclr_n mid-burst on ch1
    sclr = 2'b10; tick; sclr = '0;
    check("t6_ch0_keep", ab0, 2'b10);
    check("t6_ch1_clr", ab1, 2'b00);
    dwell = '0; step = 2'b10; dir = 2'b10;
    repeat (3) tick;
    check("t6_burst", ab1, 2'b11);
    check("t6_ch0_burst", ab0, 2'b10);
    #2; aclr_n = 1'b0; step = '0;
    #1;
    check("t6_rst_ab", {A, B}, 4'b0000);
    check("t6_rst_z", Z, 2'b11);
    check("t6_rst_busy", busy, 2'b00);
    #2; aclr_n = 1'b1;
    repeat (10) tick;
    check("t6_after_ab", {A, B}, 4'b0000);
    check("t6_after_z", Z, 2'b11);
    check("t6_after_busy", busy, 2'b00);
    $display("async clear checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
